// File: rtl/pkc_noise_arbiter.sv
// pkc_noise_arbiter: shares one noise sample source between KeyGen and Enc.
// One requester owns the source for a full N-coefficient burst; coefficients
// at index >= ACTIVE_CNT are emitted as zero without consuming the source.
module pkc_noise_arbiter #(
  parameter int p          = 1049089,
  parameter int N          = 256,
  parameter int logP       = $clog2(p),
  parameter int logN       = $clog2(N),
  parameter int ACTIVE_CNT = N
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            smp_valid,
  input  logic [logP-1:0] smp_data,
  output logic            smp_ready,
  input  logic            kg_req,
  input  logic            kg_ready,
  output logic            kg_valid,
  output logic [logP-1:0] kg_data,
  output logic            kg_done,
  input  logic            enc_req,
  input  logic            enc_ready,
  output logic            enc_valid,
  output logic [logP-1:0] enc_data,
  output logic            enc_done,
  output logic            abort,
  output logic [1:0]      grant_state,
  output logic [logN-1:0] coef_cnt
);
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT_KG = 2'd1, GRANT_ENC = 2'd2} state_t;

  // one extra bit so ACTIVE_CNT == N is representable
  localparam logic [logN:0]   ACT  = (logN+1)'(ACTIVE_CNT);
  localparam logic [logN-1:0] LAST = logN'(N-1);

  state_t          state_q, state_d;
  logic [logN-1:0] cnt_q, cnt_d;
  logic            last_enc_q, last_enc_d;  // 1: Enc owned the previous burst

  logic            own_kg, own_req, own_rdy, active, o_valid, xfer;
  logic [logP-1:0] o_data;

  // next-state and combinational datapath; reset forces every output low
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_enc_d = last_enc_q;
    own_kg     = (state_q == GRANT_KG);
    own_req    = own_kg ? kg_req : enc_req;
    own_rdy    = own_kg ? kg_ready : enc_ready;
    active     = ({1'b0, cnt_q} < ACT);
    o_valid    = 1'b0;
    o_data     = '0;
    xfer       = 1'b0;
    smp_ready  = 1'b0;
    kg_valid   = 1'b0;
    kg_data    = '0;
    kg_done    = 1'b0;
    enc_valid  = 1'b0;
    enc_data   = '0;
    enc_done   = 1'b0;
    abort      = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          // round robin on a tie: the requester that did not own last time wins
          if (kg_req && (!enc_req || last_enc_q)) state_d = GRANT_KG;
          else if (enc_req)                      state_d = GRANT_ENC;
        end
        GRANT_KG, GRANT_ENC: begin
          if (!own_req) begin
            // owner walked away: no transfer this cycle, release the source
            abort      = 1'b1;
            state_d    = IDLE;
            cnt_d      = '0;
            last_enc_d = !own_kg;
          end else begin
            // masked coefficients are always-valid zeros and leave the source alone
            o_valid   = active ? smp_valid : 1'b1;
            o_data    = active ? smp_data : '0;
            smp_ready = active && own_rdy;
            xfer      = o_valid && own_rdy;
            if (xfer) begin
              if (cnt_q == LAST) begin
                kg_done    = own_kg;
                enc_done   = !own_kg;
                state_d    = IDLE;
                cnt_d      = '0;
                last_enc_d = !own_kg;
              end else begin
                cnt_d = cnt_q + logN'(1);
              end
            end
          end
          kg_valid  = own_kg && o_valid;
          kg_data   = own_kg ? o_data : '0;
          enc_valid = !own_kg && o_valid;
          enc_data  = own_kg ? '0 : o_data;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // state, burst counter and round-robin history
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_enc_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_enc_q <= last_enc_d;
    end
  end

  assign grant_state = reset ? 2'd0 : state_q;
  assign coef_cnt    = reset ? '0 : cnt_q;
endmodule

// File: tb/tb_pkc_noise_arbiter.sv
// Bench for pkc_noise_arbiter: two instances (no masking, ACTIVE_CNT=128)
// share stimulus; a per-cycle behavioural model checks both, and directed
// scenarios pin the model with hand-computed expectations.
module tb_pkc_noise_arbiter;
  localparam int P     = 1049089;
  localparam int N     = 256;
  localparam int LP    = $clog2(P);
  localparam int LN    = $clog2(N);
  localparam int ACT_M = 128;

  logic clk = 1'b0;
  logic reset, smp_valid, kg_req, kg_ready, enc_req, enc_ready;
  logic [LP-1:0] smp_data;
  logic [1:0] smp_ready_o, kg_valid_o, kg_done_o, enc_valid_o, enc_done_o, abort_o;
  logic [1:0][LP-1:0] kg_data_o, enc_data_o;
  logic [1:0][1:0]    gs_o;
  logic [1:0][LN-1:0] cnt_o;

  logic n_reset, n_smp_valid, n_kg_req, n_kg_ready, n_enc_req, n_enc_ready;
  logic n_data_set, rnd_data;
  logic [LP-1:0] n_data;

  int tests = 0, fails = 0, cyc = 0;
  int m_own[2], m_idx[2], m_last[2];

  always #5 clk = ~clk;

  pkc_noise_arbiter #(.p(P), .N(N)) dut (
    .clk(clk), .reset(reset), .smp_valid(smp_valid), .smp_data(smp_data),
    .smp_ready(smp_ready_o[0]), .kg_req(kg_req), .kg_ready(kg_ready),
    .kg_valid(kg_valid_o[0]), .kg_data(kg_data_o[0]), .kg_done(kg_done_o[0]),
    .enc_req(enc_req), .enc_ready(enc_ready), .enc_valid(enc_valid_o[0]),
    .enc_data(enc_data_o[0]), .enc_done(enc_done_o[0]), .abort(abort_o[0]),
    .grant_state(gs_o[0]), .coef_cnt(cnt_o[0]));

  pkc_noise_arbiter #(.p(P), .N(N), .ACTIVE_CNT(ACT_M)) dut_m (
    .clk(clk), .reset(reset), .smp_valid(smp_valid), .smp_data(smp_data),
    .smp_ready(smp_ready_o[1]), .kg_req(kg_req), .kg_ready(kg_ready),
    .kg_valid(kg_valid_o[1]), .kg_data(kg_data_o[1]), .kg_done(kg_done_o[1]),
    .enc_req(enc_req), .enc_ready(enc_ready), .enc_valid(enc_valid_o[1]),
    .enc_data(enc_data_o[1]), .enc_done(enc_done_o[1]), .abort(abort_o[1]),
    .grant_state(gs_o[1]), .coef_cnt(cnt_o[1]));

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Behavioural model: owner 0/1/2 (none/KG/ENC), burst index, previous owner.
  task automatic model_cycle(input int k, input int act, output logic [57:0] e);
    int own, idx, req, rdy, v, d, sr, done, ab;
    own = m_own[k]; idx = m_idx[k];
    v = 0; d = 0; sr = 0; done = 0; ab = 0;
    e = '0;
    if (reset) begin
      m_own[k] = 0; m_idx[k] = 0; m_last[k] = 2;
    end else if (own == 0) begin
      if (kg_req && (!enc_req || m_last[k] == 2)) m_own[k] = 1;
      else if (enc_req)                           m_own[k] = 2;
    end else begin
      req = (own == 1) ? int'(kg_req) : int'(enc_req);
      rdy = (own == 1) ? int'(kg_ready) : int'(enc_ready);
      if (req == 0) begin
        ab = 1; m_own[k] = 0; m_idx[k] = 0; m_last[k] = own;
      end else begin
        if (idx >= act) begin v = 1; d = 0; sr = 0; end
        else begin v = int'(smp_valid); d = int'(smp_data); sr = rdy; end
        if (v != 0 && rdy != 0) begin
          if (idx == N-1) begin
            done = 1; m_own[k] = 0; m_idx[k] = 0; m_last[k] = own;
          end else m_idx[k] = idx + 1;
        end
      end
      e = {2'(own), LN'(idx),
           (own == 1) && (v != 0), LP'((own == 1) ? d : 0), (own == 1) && (done != 0),
           (own == 2) && (v != 0), LP'((own == 2) ? d : 0), (own == 2) && (done != 0),
           sr != 0, ab != 0};
    end
  endtask

  // every-cycle compare of both instances against the model
  always @(negedge clk) begin : cmp
    logic [57:0] e, a;
    for (int k = 0; k < 2; k++) begin
      model_cycle(k, (k == 0) ? N : ACT_M, e);
      a = {gs_o[k], cnt_o[k], kg_valid_o[k], kg_data_o[k], kg_done_o[k],
           enc_valid_o[k], enc_data_o[k], enc_done_o[k], smp_ready_o[k], abort_o[k]};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL model dut%0d (cycle %0d): got %h, expected %h", k, cyc, a, e);
      end
    end
  end

  // called at a negedge: apply next-cycle inputs just after the posedge
  task automatic step();
    logic c;
    c = smp_valid && smp_ready_o[0];
    @(posedge clk); #1;
    reset = n_reset; smp_valid = n_smp_valid; kg_req = n_kg_req;
    kg_ready = n_kg_ready; enc_req = n_enc_req; enc_ready = n_enc_ready;
    if (n_data_set) begin smp_data = n_data; n_data_set = 1'b0; end
    else if (c) smp_data = rnd_data ? LP'($urandom_range(0, P-1)) : smp_data + 1'b1;
    cyc++;
  endtask

  task automatic nxt();
    step();
    @(negedge clk);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int nb, prev, idle, ev_bad, cons, dn, xf, ab, ed;
    int owners[4], gaps[4];
    logic [LP-1:0] q[$];
    logic [LP-1:0] ex;
    reset = 1; smp_valid = 0; kg_req = 0; kg_ready = 0; enc_req = 0; enc_ready = 0;
    smp_data = '0; rnd_data = 0; n_data_set = 0; n_data = '0;
    n_reset = 1; n_smp_valid = 0; n_kg_req = 0; n_kg_ready = 0; n_enc_req = 0; n_enc_ready = 0;

    // 1: reset for 2 cycles, then one full KG burst of index data
    @(negedge clk);
    chk("t1 reset grant_state", gs_o[0], 0);
    chk("t1 reset kg_valid", kg_valid_o[0], 0);
    nxt();
    n_reset = 0; n_kg_req = 1; n_smp_valid = 1; n_kg_ready = 1;
    n_data_set = 1; n_data = '0;
    nxt();
    chk("t1 idle after reset", gs_o[0], 0);
    chk("t1 idle kg_valid", kg_valid_o[0], 0);
    nxt();
    chk("t1 grant kg", gs_o[0], 1);
    for (int i = 0; i < N; i++) begin
      chk("t1 kg_data", kg_data_o[0], i);
      chk("t1 coef_cnt", cnt_o[0], i);
      chk("t1 kg_done", kg_done_o[0], (i == N-1));
      if (i == N-1) n_kg_req = 0;
      nxt();
    end
    chk("t1 back to idle", gs_o[0], 0);

    // 2: both requests held from reset -> KG, ENC, KG, ENC with 1 idle cycle
    n_reset = 1; nxt();
    n_reset = 0; n_kg_req = 1; n_enc_req = 1; n_enc_ready = 1;
    nxt();
    nb = 0; prev = 0; idle = 0; ev_bad = 0;
    for (int i = 0; i < 4; i++) begin owners[i] = 0; gaps[i] = -1; end
    for (int t = 0; t < 1200 && !(nb == 4 && gs_o[0] == 0); t++) begin
      if (gs_o[0] != 0 && prev == 0 && nb < 4) begin
        owners[nb] = gs_o[0]; gaps[nb] = idle; nb++;
      end
      idle = (gs_o[0] == 0) ? idle + 1 : 0;
      if (gs_o[0] == 1 && enc_valid_o[0]) ev_bad++;
      if (nb == 4 && cnt_o[0] == LN'(N-1)) begin n_kg_req = 0; n_enc_req = 0; end
      prev = gs_o[0];
      nxt();
    end
    chk("t2 burst count", nb, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2 burst owner", owners[i], (i % 2 == 0) ? 1 : 2);
      chk("t2 idle gap", gaps[i], 1);
    end
    chk("t2 enc_valid during kg", ev_bad, 0);

    // 3: masked instance, Enc burst: 128 live samples then 128 zeros
    n_enc_req = 1; n_data_set = 1; n_data = LP'(1000);
    nxt();
    for (int t = 0; t < 5 && gs_o[1] != 2; t++) nxt();
    chk("t3 grant enc", gs_o[1], 2);
    cons = 0; dn = 0;
    for (int i = 0; i < N; i++) begin
      if (i < ACT_M) chk("t3 live data", enc_data_o[1], smp_data);
      else begin
        chk("t3 masked data", enc_data_o[1], 0);
        chk("t3 masked smp_ready", smp_ready_o[1], 0);
      end
      if (smp_valid && smp_ready_o[1]) cons++;
      dn += int'(enc_done_o[1]);
      if (i == N-1) n_enc_req = 0;
      nxt();
    end
    chk("t3 source consumed", cons, ACT_M);
    chk("t3 enc_done count", dn, 1);
    chk("t3 back to idle", gs_o[1], 0);

    // 4: random stalls on both sides; data order must be preserved
    rnd_data = 1; n_kg_req = 1;
    xf = 0; dn = 0;
    for (int t = 0; t < 4000 && dn == 0; t++) begin
      if (smp_valid && smp_ready_o[0]) q.push_back(smp_data);
      if (kg_valid_o[0] && kg_ready) begin
        xf++;
        ex = (q.size() > 0) ? q.pop_front() : ~kg_data_o[0];
        chk("t4 data order", kg_data_o[0], ex);
      end
      if (kg_done_o[0]) begin dn++; n_kg_req = 0; end
      n_smp_valid = 1'($urandom_range(0, 1));
      n_kg_ready  = 1'($urandom_range(0, 1));
      nxt();
    end
    chk("t4 transfers", xf, N);
    chk("t4 kg_done count", dn, 1);
    chk("t4 leftover samples", q.size(), 0);
    rnd_data = 0; n_smp_valid = 1; n_kg_ready = 1;
    for (int t = 0; t < 3; t++) begin
      dn += int'(kg_done_o[0]);
      nxt();
    end
    chk("t4 no extra done", dn, 1);

    // 5: Enc drops req at coef 100 while KG waits
    n_enc_req = 1; n_kg_req = 0;
    nxt();
    for (int t = 0; t < 5 && gs_o[0] != 2; t++) nxt();
    chk("t5 grant enc", gs_o[0], 2);
    ab = 0; ed = 0;
    for (int t = 0; t < 300 && cnt_o[0] != LN'(100); t++) begin
      if (cnt_o[0] == LN'(99)) begin n_enc_req = 0; n_kg_req = 1; end
      ab += int'(abort_o[0]); ed += int'(enc_done_o[0]);
      nxt();
    end
    chk("t5 coef reached", cnt_o[0], 100);
    chk("t5 no early abort", ab, 0);
    chk("t5 abort pulse", abort_o[0], 1);
    chk("t5 enc_valid on abort", enc_valid_o[0], 0);
    chk("t5 smp_ready on abort", smp_ready_o[0], 0);
    chk("t5 no enc_done", enc_done_o[0] | 1'(ed != 0), 0);
    nxt();
    chk("t5 idle after abort", gs_o[0], 0);
    chk("t5 abort one cycle", abort_o[0], 0);
    nxt();
    chk("t5 kg granted", gs_o[0], 1);
    n_kg_req = 0;
    nxt(); nxt();

    // 6: reset at coef 50 of a KG burst, then both request
    n_kg_req = 1;
    nxt();
    for (int t = 0; t < 5 && gs_o[0] != 1; t++) nxt();
    chk("t6 grant kg", gs_o[0], 1);
    for (int t = 0; t < 300 && cnt_o[0] != LN'(49); t++) nxt();
    n_reset = 1;
    nxt();
    chk("t6 reset kg_done", kg_done_o[0], 0);
    chk("t6 reset abort", abort_o[0], 0);
    chk("t6 reset kg_valid", kg_valid_o[0], 0);
    n_reset = 0; n_enc_req = 1;
    nxt();
    chk("t6 idle after reset", gs_o[0], 0);
    chk("t6 coef_cnt cleared", cnt_o[0], 0);
    chk("t6 no abort after reset", abort_o[0], 0);
    nxt();
    chk("t6 kg wins first", gs_o[0], 1);
    n_kg_req = 0; n_enc_req = 0;
    nxt(); nxt(); nxt();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
